regfile_access_sequencer: RTL and testbench
===========================================

Name: regfile_access_sequencer

Overview:
- Multi-cycle master for the 18-bit, 16-entry register file.
- Accepts one decoded instruction at a time, drives the register file read addresses and honours its one-cycle registered read latency.
- Hands both operands to the ALU over a valid/ready handshake, waits for the result, then drives the register file write port for writeback.
- Sits between the decoder and the ALU / register file pair in the datapath.

Parameters:
- DATA_W, 18, operand/result width; equals register width.
- ADDR_W, 5, register address width on all address ports.
- NUM_REGS, 16, implemented registers; addresses >= NUM_REGS are illegal.
- RESULT_TIMEOUT, 255, maximum WAIT cycles before abort; 1..255.

Ports:
- clck  in  1  single clock; all state updates on rising edge.
- reset_enable  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decoder has an instruction.
- dec_ready  out  1  sequencer can accept an instruction.
- dec_src1  in  ADDR_W  operand A register.
- dec_src2  in  ADDR_W  operand B register.
- dec_dest  in  ADDR_W  destination register.
- dec_wb  in  1  1 = write the result back.
- rf_reg_1  out  ADDR_W  register file read address 1.
- rf_reg_2  out  ADDR_W  register file read address 2.
- rf_read_value_1  in  DATA_W  register file read data 1 (registered, 1-cycle latency).
- rf_read_value_2  in  DATA_W  register file read data 2.
- rf_select_register  out  ADDR_W  register file write address.
- rf_data  out  DATA_W  register file write data.
- rf_write_enable  out  1  register file write strobe.
- alu_valid  out  1  operands valid.
- alu_ready  in  1  ALU accepts operands.
- alu_op_a  out  DATA_W  operand A.
- alu_op_b  out  DATA_W  operand B.
- res_valid  in  1  ALU result valid; 1-cycle pulse.
- res_data  in  DATA_W  ALU result.
- busy  out  1  high in every state except IDLE.
- addr_err  out  1  sticky: illegal address was offered.
- timeout_err  out  1  sticky: result timeout occurred.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE. Every output, internal latch and counter = 0, including dec_ready. dec_ready rises to 1 on the first clck edge after reset deasserts.
- Reset mid-operation: transaction abandoned, no register file write issued, both sticky flags cleared.
- IDLE: dec_ready = 1.
  - Handshake occurs on the edge where dec_valid && dec_ready.
  - On handshake, latch src1, src2, dest and wb.
  - If src1 >= NUM_REGS, or src2 >= NUM_REGS, or (wb && dest >= NUM_REGS): set addr_err, drop the instruction, stay in IDLE.
  - Otherwise go to READ.
- READ (1 cycle): dec_ready = 0. rf_reg_1/rf_reg_2 are driven from the latched src fields; they hold those values in every state until the next accept. Next state: CAPTURE.
- CAPTURE (1 cycle): register file read data is valid. Latch it into alu_op_a/alu_op_b at the end of the cycle. Next state: ISSUE.
- ISSUE: alu_valid = 1; alu_op_a/b stay stable until the handshake.
  - On an edge with alu_ready = 1: alu_valid drops, WAIT counter cleared, go to WAIT.
  - No timeout in ISSUE.
- WAIT: counter increments each cycle.
  - On an edge with res_valid: latch res_data into rf_data. Go to WB if wb, else IDLE.
  - If the counter reaches RESULT_TIMEOUT without res_valid: set timeout_err, go to IDLE, no write.
  - If res_valid and timeout coincide, res_valid wins.
- WB (1 cycle): rf_write_enable = 1, rf_select_register = latched dest, rf_data = result. Next state: IDLE. rf_write_enable is never high outside WB.
- res_valid is ignored outside WAIT. The ALU must not respond in the handshake cycle itself.
- Latency: with alu_ready held high and a 1-cycle ALU, accept edge to write edge = 5 edges (READ, CAPTURE, ISSUE, WAIT, WB).
- Throughput: one instruction per 5+ cycles.
- RAW hazard: the next instruction's READ latch edge is always at least 2 edges after the WB write edge, so back-to-back dependent instructions read the new value with no bypass.
- Arithmetic: the WAIT counter is 8 bits and saturates; no wrap.

Optional Feature:
- Macro: RAS_ZERO_REG_EN.
- Defined: register 0 reads as zero and is never written.
  - Operand whose src = 0 is forced to 0 in CAPTURE, regardless of rf_read_value.
  - dest = 0 with wb = 1 skips WB and returns to IDLE from WAIT.
- Undefined: register 0 behaves as a general register.

Test Plan:
- Reset mid-WAIT, then release -> no rf_write_enable pulse; all outputs 0; dec_ready = 1 one edge after release.
- Accept src1=3, src2=4, dest=5, wb=1; rf values 0x00012, 0x00034; ALU returns 0x00046 one cycle after handshake -> alu_op_a=0x00012, alu_op_b=0x00034; one-cycle write of 0x00046 to register 5, fifth edge after accept.
- Back-to-back: write R5=0x3FFFF, then src1=5 -> alu_op_a=0x3FFFF.
- alu_ready low for 4 cycles in ISSUE -> alu_valid held, operands stable, nothing lost.
- dec_src2=16 -> addr_err=1, stays IDLE, no read or write; with wb=0, dest=20 is accepted normally.
- RESULT_TIMEOUT=8, res_valid never asserted -> timeout_err=1 after 8 WAIT cycles, IDLE, no write. With RAS_ZERO_REG_EN: dest=0, wb=1 -> no write; src1=0 -> alu_op_a=0.

Source files
------------

// File: rtl/regfile_access_sequencer.sv
// Multi-cycle sequencer: decoder -> register file read -> ALU handshake -> writeback.
// Optional macro RAS_ZERO_REG_EN makes register 0 read as zero and never be written.
module regfile_access_sequencer #(
  parameter int DATA_W         = 18,
  parameter int ADDR_W         = 5,
  parameter int NUM_REGS       = 16,
  parameter int RESULT_TIMEOUT = 255
) (
  input  logic              clck,
  input  logic              reset_enable,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [ADDR_W-1:0] dec_src1,
  input  logic [ADDR_W-1:0] dec_src2,
  input  logic [ADDR_W-1:0] dec_dest,
  input  logic              dec_wb,
  output logic [ADDR_W-1:0] rf_reg_1,
  output logic [ADDR_W-1:0] rf_reg_2,
  input  logic [DATA_W-1:0] rf_read_value_1,
  input  logic [DATA_W-1:0] rf_read_value_2,
  output logic [ADDR_W-1:0] rf_select_register,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_write_enable,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              addr_err,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t              state_q;
  logic                dec_ready_q;
  logic [ADDR_W-1:0]   src1_q;
  logic [ADDR_W-1:0]   src2_q;
  logic [ADDR_W-1:0]   dest_q;
  logic                wb_q;
  logic [ADDR_W-1:0]   rf_sel_q;
  logic [DATA_W-1:0]   rf_data_q;
  logic                rf_we_q;
  logic                alu_valid_q;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic                busy_q;
  logic                addr_err_q;
  logic                timeout_err_q;
  logic [7:0]          wait_cnt_q;

  logic                accept_d;
  logic                bad_addr_d;
  logic [7:0]          wait_cnt_d;
  logic                timeout_hit_d;
  logic                wb_write_d;
  logic [DATA_W-1:0]   op_a_d;
  logic [DATA_W-1:0]   op_b_d;

  always_comb begin
    accept_d      = dec_valid && dec_ready_q;
    bad_addr_d    = (int'(dec_src1) >= NUM_REGS) || (int'(dec_src2) >= NUM_REGS) ||
                    (dec_wb && (int'(dec_dest) >= NUM_REGS));
    wait_cnt_d    = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    timeout_hit_d = (wait_cnt_q >= 8'(RESULT_TIMEOUT - 1));
`ifdef RAS_ZERO_REG_EN
    wb_write_d    = wb_q && (dest_q != '0);
    op_a_d        = (src1_q == '0) ? '0 : rf_read_value_1;
    op_b_d        = (src2_q == '0) ? '0 : rf_read_value_2;
`else
    wb_write_d    = wb_q;
    op_a_d        = rf_read_value_1;
    op_b_d        = rf_read_value_2;
`endif
  end

  always_ff @(posedge clck or posedge reset_enable) begin
    if (reset_enable) begin
      state_q       <= S_IDLE;
      dec_ready_q   <= 1'b0;
      src1_q        <= '0;
      src2_q        <= '0;
      dest_q        <= '0;
      wb_q          <= 1'b0;
      rf_sel_q      <= '0;
      rf_data_q     <= '0;
      rf_we_q       <= 1'b0;
      alu_valid_q   <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      busy_q        <= 1'b0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dec_ready_q <= 1'b1;
          if (accept_d) begin
            if (bad_addr_d) begin
              addr_err_q <= 1'b1;
            end else begin
              // Source fields double as the read addresses until the next accept.
              src1_q      <= dec_src1;
              src2_q      <= dec_src2;
              dest_q      <= dec_dest;
              wb_q        <= dec_wb;
              dec_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= S_READ;
            end
          end
        end
        S_READ: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          op_a_q      <= op_a_d;
          op_b_q      <= op_b_d;
          alu_valid_q <= 1'b1;
          state_q     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (alu_ready) begin
            alu_valid_q <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_d;
          // A result arriving on the timeout edge still counts.
          if (res_valid) begin
            rf_data_q <= res_data;
            if (wb_write_d) begin
              rf_we_q  <= 1'b1;
              rf_sel_q <= dest_q;
              state_q  <= S_WB;
            end else begin
              busy_q      <= 1'b0;
              dec_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end else if (timeout_hit_d) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            dec_ready_q   <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_WB: begin
          rf_we_q     <= 1'b0;
          busy_q      <= 1'b0;
          dec_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dec_ready          = dec_ready_q;
  assign rf_reg_1           = src1_q;
  assign rf_reg_2           = src2_q;
  assign rf_select_register = rf_sel_q;
  assign rf_data            = rf_data_q;
  assign rf_write_enable    = rf_we_q;
  assign alu_valid          = alu_valid_q;
  assign alu_op_a           = op_a_q;
  assign alu_op_b           = op_b_q;
  assign busy               = busy_q;
  assign addr_err           = addr_err_q;
  assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Randomized bench for regfile_access_sequencer with a behavioural register-file/ALU model.
module tb_regfile_access_sequencer;
  localparam int DW = 18;
  localparam int AW = 5;
  localparam int NR = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dec_valid, dec_ready, dec_wb;
  logic [AW-1:0] dec_src1, dec_src2, dec_dest;
  logic [AW-1:0] rf_reg_1, rf_reg_2, rf_select_register;
  logic [DW-1:0] rf_read_value_1, rf_read_value_2, rf_data;
  logic          rf_write_enable, alu_valid, alu_ready, res_valid;
  logic [DW-1:0] alu_op_a, alu_op_b, res_data;
  logic          busy, addr_err, timeout_err;

  always #5 clk = ~clk;

  regfile_access_sequencer #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RESULT_TIMEOUT(TO)
  ) dut (
    .clck(clk), .reset_enable(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_dest(dec_dest), .dec_wb(dec_wb),
    .rf_reg_1(rf_reg_1), .rf_reg_2(rf_reg_2),
    .rf_read_value_1(rf_read_value_1), .rf_read_value_2(rf_read_value_2),
    .rf_select_register(rf_select_register), .rf_data(rf_data),
    .rf_write_enable(rf_write_enable),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .addr_err(addr_err), .timeout_err(timeout_err)
  );

  // Register file with a registered read port; preload path used only while the DUT is idle.
  logic [DW-1:0] rf_mem [0:31];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  int            writes_seen = 0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rf_read_value_1 <= rf_mem[rf_reg_1];
    rf_read_value_2 <= rf_mem[rf_reg_2];
    if (pre_we) rf_mem[pre_addr] <= pre_data;
    else if (rf_write_enable) begin
      rf_mem[rf_select_register] <= rf_data;
      writes_seen <= writes_seen + 1;
    end
  end

  // Reference state
  logic [DW-1:0] ref_regs [0:31];
  logic          exp_addr_err = 1'b0;
  logic          exp_to_err = 1'b0;
  int            writes_expected = 0;
  int            tests_run = 0;
  int            tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic outs_any();
    return dec_ready | alu_valid | rf_write_enable | busy | addr_err | timeout_err |
           (|rf_reg_1) | (|rf_reg_2) | (|rf_select_register) | (|rf_data) |
           (|alu_op_a) | (|alu_op_b);
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(negedge clk);
    pre_we = 1'b0;
    ref_regs[a] = v;
  endtask

  // One instruction, starting and ending on a negedge with the DUT idle.
  task automatic run_instr(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic [AW-1:0] d, input logic wb,
                           input int rdly, input int resdly, input logic no_res,
                           input logic [DW-1:0] res);
    logic          illegal, do_write;
    logic [DW-1:0] ea, eb;
    int            acc, n;
    illegal  = (int'(s1) >= NR) || (int'(s2) >= NR) || (wb && int'(d) >= NR);
    ea       = ref_regs[s1];
    eb       = ref_regs[s2];
    do_write = wb && !no_res;
`ifdef RAS_ZERO_REG_EN
    if (s1 == 0) ea = '0;
    if (s2 == 0) eb = '0;
    if (d == 0) do_write = 1'b0;
`endif
    $display("[TB] instr src1=%0d src2=%0d dest=%0d wb=%0d rdly=%0d resdly=%0d nores=%0d res=0x%05h",
             s1, s2, d, wb, rdly, resdly, no_res, res);
    check("dec_ready_idle", dec_ready, 1);
    dec_valid = 1'b1; dec_src1 = s1; dec_src2 = s2; dec_dest = d; dec_wb = wb;
    @(negedge clk);
    acc = cyc;
    dec_valid = 1'b0;
    if (illegal) begin
      exp_addr_err = 1'b1;
      check("addr_err_set", addr_err, 1);
      check("illegal_busy", busy, 0);
      check("illegal_ready", dec_ready, 1);
    end else begin
      check("accept_busy", busy, 1);
      check("accept_ready", dec_ready, 0);
      n = 0;
      while (!alu_valid && n < 10) begin @(negedge clk); n++; end
      check("alu_valid_seen", alu_valid, 1);
      check("issue_latency", cyc - acc, 2);
      check("rf_reg_1", rf_reg_1, s1);
      check("rf_reg_2", rf_reg_2, s2);
      check("alu_op_a", alu_op_a, ea);
      check("alu_op_b", alu_op_b, eb);
      for (int i = 0; i < rdly; i++) begin
        res_valid = (i == 0) && (rdly >= 2);   // stray pulse outside WAIT, must be ignored
        res_data  = ~res;
        @(negedge clk);
        res_valid = 1'b0;
      end
      if (rdly > 0) begin
        check("hold_valid", alu_valid, 1);
        check("hold_op_a", alu_op_a, ea);
        check("hold_op_b", alu_op_b, eb);
      end
      alu_ready = 1'b1;
      @(negedge clk);
      alu_ready = 1'b0;
      check("alu_valid_drop", alu_valid, 0);
      if (no_res) begin
        n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        exp_to_err = 1'b1;
        check("timeout_cycles", n, TO);
        check("timeout_we", rf_write_enable, 0);
      end else begin
        repeat (resdly) @(negedge clk);
        res_valid = 1'b1; res_data = res;
        @(negedge clk);
        res_valid = 1'b0;
        if (do_write) begin
          check("wb_we", rf_write_enable, 1);
          check("wb_sel", rf_select_register, d);
          check("wb_data", rf_data, res);
          check("wb_latency", cyc - acc, 4 + rdly + resdly);
          @(negedge clk);
          ref_regs[d] = res;
          writes_expected++;
        end
        check("done_we", rf_write_enable, 0);
      end
      check("done_busy", busy, 0);
      check("done_ready", dec_ready, 1);
    end
    check("addr_err", addr_err, exp_addr_err);
    check("timeout_err", timeout_err, exp_to_err);
    check("write_count", writes_seen, writes_expected);
  endtask

  initial begin
    int n;
    dec_valid = 0; dec_src1 = '0; dec_src2 = '0; dec_dest = '0; dec_wb = 0;
    alu_ready = 0; res_valid = 0; res_data = '0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) preload(5'(i), DW'($urandom_range(0, 262143)));
    check("reset_outputs", outs_any(), 0);
    rst = 1'b0;
    #1 check("ready_before_edge", dec_ready, 0);
    @(negedge clk);
    check("ready_after_release", dec_ready, 1);

    preload(5'd3, 18'h00012);
    preload(5'd4, 18'h00034);
    run_instr(5'd3, 5'd4, 5'd5, 1'b1, 0, 0, 1'b0, 18'h00046);
    run_instr(5'd1, 5'd2, 5'd5, 1'b1, 0, 0, 1'b0, 18'h3FFFF);
    run_instr(5'd5, 5'd6, 5'd7, 1'b1, 0, 0, 1'b0, 18'h0ABCD);
    run_instr(5'd7, 5'd8, 5'd9, 1'b1, 4, 1, 1'b0, 18'h12345);
    run_instr(5'd1, 5'd16, 5'd2, 1'b1, 0, 0, 1'b0, 18'h00001);
    run_instr(5'd2, 5'd3, 5'd20, 1'b0, 0, 0, 1'b0, 18'h00002);
    run_instr(5'd4, 5'd5, 5'd6, 1'b1, 0, 0, 1'b1, 18'h00000);
    run_instr(5'd0, 5'd3, 5'd0, 1'b1, 1, 2, 1'b0, 18'h2AAAA);
    run_instr(5'd0, 5'd0, 5'd8, 1'b1, 0, 0, 1'b0, 18'h15555);

    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] s1, s2, d;
      s1 = ($urandom_range(0, 9) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 15));
      s2 = ($urandom_range(0, 9) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 15));
      d  = ($urandom_range(0, 9) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 15));
      run_instr(s1, s2, d, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0),
                DW'($urandom_range(0, 262143)));
    end

    // Reset while waiting for a result: nothing may be written, sticky flags clear.
    $display("[TB] reset during WAIT");
    dec_valid = 1'b1; dec_src1 = 5'd1; dec_src2 = 5'd2; dec_dest = 5'd3; dec_wb = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0;
    n = 0;
    while (!alu_valid && n < 10) begin @(negedge clk); n++; end
    check("mid_alu_valid", alu_valid, 1);
    alu_ready = 1'b1;
    @(negedge clk);
    alu_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("mid_reset_outputs", outs_any(), 0);
    @(negedge clk);
    res_valid = 1'b1; res_data = 18'h11111;
    @(negedge clk);
    res_valid = 1'b0;
    rst = 1'b0;
    exp_addr_err = 1'b0; exp_to_err = 1'b0;
    #1 check("mid_ready_before_edge", dec_ready, 0);
    check("mid_no_write", writes_seen, writes_expected);
    @(negedge clk);
    check("mid_ready_after", dec_ready, 1);
    check("mid_addr_err", addr_err, 0);
    check("mid_timeout_err", timeout_err, 0);
    check("mid_we", rf_write_enable, 0);
    run_instr(5'd3, 5'd4, 5'd10, 1'b1, 0, 0, 1'b0, 18'h0F0F0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got 0x0, expected 0x1");
    $fatal(1, "time limit");
  end
endmodule
